stage3_execute: RTL

STAGE3_EXECUTE -- requirements
Module: stage3_execute

---
 rtl/rv_pkg.sv | 38 +++
 rtl/muldiv_iter.sv | 134 +++++++++++++
 rtl/stage3_execute.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the execute stage: ALU and RV32M opcodes plus the
// iterative M-unit state machine.
package rv_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on magnitudes,
// one bit per cycle, with sign fix-up and corner cases applied in DONE.
module muldiv_iter
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  md_state_e         state_q, state_d;
  logic [4:0]        cnt_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] hi_q, lo_q, opb_q, a_q, result_q;
  logic              neg_lo_q, neg_rem_q, bzero_q, done_q;

  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   mul_sum, div_rem, div_diff;
  logic [63:0]       prod, prod_s;
  logic [DATA_W-1:0] quo, rem, final_res;

  // Operand signedness depends on the op; the core loops only see magnitudes.
  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    case (md_op_e'(op))
      MD_MULH, MD_DIV, MD_REM: begin
        a_neg = a[DATA_W-1];
        b_neg = b[DATA_W-1];
      end
      MD_MULHSU: a_neg = a[DATA_W-1];
      default: ;
    endcase
  end

  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign div_rem  = {hi_q, lo_q[DATA_W-1]};
  assign div_diff = div_rem - {1'b0, opb_q};

  // Divide-by-zero is forced explicitly; overflow falls out of the magnitude path.
  always_comb begin
    prod      = {hi_q, lo_q};
    prod_s    = neg_lo_q ? -prod : prod;
    quo       = bzero_q ? '1 : (neg_lo_q ? -lo_q : lo_q);
    rem       = bzero_q ? a_q : (neg_rem_q ? -hi_q : hi_q);
    final_res = '0;
    case (md_op_e'(op_q))
      MD_MUL:                       final_res = prod_s[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_s[63:32];
      MD_DIV, MD_DIVU:              final_res = quo;
      default:                      final_res = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (start && !done_q) state_d = op[2] ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (cnt_q == 5'd31) state_d = S_DONE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else if (!hold)
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      a_q       <= '0;
      result_q  <= '0;
      neg_lo_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      done_q    <= 1'b0;
    end else if (!hold) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start && !done_q) begin
          op_q      <= op;
          cnt_q     <= '0;
          hi_q      <= '0;
          lo_q      <= a_mag;
          opb_q     <= b_mag;
          a_q       <= a;
          neg_lo_q  <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          bzero_q   <= (b == '0);
        end
        S_MUL: begin
          {hi_q, lo_q} <= {mul_sum, lo_q[DATA_W-1:1]};
          cnt_q        <= cnt_q + 5'd1;
        end
        S_DIV: begin
          if (!div_diff[DATA_W]) begin
            hi_q <= div_diff[DATA_W-1:0];
            lo_q <= {lo_q[DATA_W-2:0], 1'b1};
          end else begin
            hi_q <= div_rem[DATA_W-1:0];
            lo_q <= {lo_q[DATA_W-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 5'd1;
        end
        default: begin
          result_q <= final_res;
          done_q   <= 1'b1;
        end
      endcase
    end
  end

  assign busy   = (state_q != S_IDLE) || done_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: rtl/stage3_execute.sv
// Execute stage: single-cycle ALU plus optional iterative RV32M unit, feeding
// registered results and control to the memory stage.
module stage3_execute
  import rv_pkg::*;
#(
  parameter int MULDIV_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        valid_in,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic        use_imm,
  input  logic [3:0]  alu_op,
  input  logic        is_muldiv,
  input  logic [2:0]  muldiv_op,
  input  logic [4:0]  rd_idx,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic        reg_write_enable,
  output logic [31:0] alu_res,
  output logic [31:0] rs2_val_out,
  output logic [4:0]  rd_idx_out,
  output logic        mem_read_enable_out,
  output logic        mem_write_enable_out,
  output logic        reg_write_enable_out,
  output logic        busy
);

  function automatic logic [DATA_W-1:0] alu_calc(input logic [3:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa, sb;
    sa = a;
    sb = b;
    case (alu_op_e'(op))
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, sa < sb};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return sa >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return '0;
    endcase
  endfunction

  logic [DATA_W-1:0] op_b;
  logic              accept, md_start, md_busy, md_done;
  logic [DATA_W-1:0] md_result;
  logic [4:0]        rd_p0;
  logic              mr_p0, mw_p0, rw_p0;
  logic [DATA_W-1:0] rs2_p0;

  assign op_b     = use_imm ? imm : rs2_val;
  assign accept   = valid_in && !md_busy && !stall;
  assign md_start = accept && is_muldiv && (MULDIV_EN != 0);
  assign busy     = md_busy;

  generate
    if (MULDIV_EN != 0) begin : g_md
      muldiv_iter u_md (
        .clk    (clk),
        .rst    (rst),
        .hold   (stall),
        .start  (md_start),
        .op     (muldiv_op),
        .a      (rs1_val),
        .b      (rs2_val),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
      );
    end else begin : g_no_md
      assign md_busy   = 1'b0;
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  // Stage p0: side-band held for the M result while the unit iterates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_p0  <= '0;
      mr_p0  <= 1'b0;
      mw_p0  <= 1'b0;
      rw_p0  <= 1'b0;
      rs2_p0 <= '0;
    end else if (md_start) begin
      rd_p0  <= rd_idx;
      mr_p0  <= mem_read_enable;
      mw_p0  <= mem_write_enable;
      rw_p0  <= reg_write_enable;
      rs2_p0 <= rs2_val;
    end
  end

  // Stage p1: output registers to memory stage; bubble unless something completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_res              <= '0;
      rs2_val_out          <= '0;
      rd_idx_out           <= '0;
      mem_read_enable_out  <= 1'b0;
      mem_write_enable_out <= 1'b0;
      reg_write_enable_out <= 1'b0;
    end else if (!stall) begin
      alu_res              <= '0;
      rs2_val_out          <= '0;
      rd_idx_out           <= '0;
      mem_read_enable_out  <= 1'b0;
      mem_write_enable_out <= 1'b0;
      reg_write_enable_out <= 1'b0;
      if (md_done) begin
        alu_res              <= md_result;
        rs2_val_out          <= rs2_p0;
        rd_idx_out           <= rd_p0;
        mem_read_enable_out  <= mr_p0;
        mem_write_enable_out <= mw_p0;
        reg_write_enable_out <= rw_p0;
      end else if (accept && !md_start) begin
        alu_res              <= is_muldiv ? '0 : alu_calc(alu_op, rs1_val, op_b);
        rs2_val_out          <= rs2_val;
        rd_idx_out           <= rd_idx;
        mem_read_enable_out  <= mem_read_enable;
        mem_write_enable_out <= mem_write_enable;
        reg_write_enable_out <= reg_write_enable;
      end
    end
  end

endmodule
